// File: rtl/ovf_mon_pkg.sv
// Shared types for the overflow-sequence monitor: per-channel FSM states,
// verdict fail codes and a small popcount helper used by the aggregator.
package ovf_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_FALL = 2'd1,
    ST_HOLD      = 2'd2
  } ovf_state_e;

  typedef enum logic [2:0] {
    FC_NONE    = 3'd0,
    FC_NOHI    = 3'd1,
    FC_EARLY   = 3'd2,
    FC_TIMEOUT = 3'd3,
    FC_GLITCH  = 3'd4,
    FC_ORDER   = 3'd5,
    FC_HOLD_TO = 3'd6
  } fail_code_e;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ovf_chan_fsm.sv
// One monitored channel: input edge registers, the IDLE/WAIT_FALL/HOLD
// sequence FSM, the phase delay counter and registered verdict pulses.
module ovf_chan_fsm
  import ovf_mon_pkg::*;
#(
  parameter int unsigned MIN_DLY  = 2,
  parameter int unsigned MAX_DLY  = 20,
  parameter int unsigned HOLD_MAX = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       start_i,
  input  logic       o_ovf_i,
  input  logic       i_ovf_i,
  output logic       pass_o,
  output logic       fail_o,
  output fail_code_e code_o,
  output logic       busy_o
);

  localparam int unsigned DLY_TOP = (MAX_DLY > HOLD_MAX) ? MAX_DLY : HOLD_MAX;
  localparam int unsigned DW      = $clog2(DLY_TOP + 1);

  ovf_state_e state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic start_prev_q, oovf_prev_q, iovf_prev_q;
  logic pass_q, pass_d, fail_q, fail_d;
  fail_code_e code_q, code_d;

  logic start_rise_s, oovf_rise_s, iovf_rise_s;

  assign start_rise_s = start_i & ~start_prev_q;
  assign oovf_rise_s  = o_ovf_i & ~oovf_prev_q;
  assign iovf_rise_s  = i_ovf_i & ~iovf_prev_q;

  // Counter value k is the number of cycles since the arm/entry decision.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    code_d  = FC_NONE;
    if (!en_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_rise_s && o_ovf_i) begin
            state_d = ST_WAIT_FALL;
            cnt_d   = DW'(1);
          end else if (start_rise_s) begin
            fail_d = 1'b1;
            code_d = FC_NOHI;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_FALL: begin
          if (!o_ovf_i && (cnt_q < DW'(MIN_DLY))) begin
            fail_d  = 1'b1;
            code_d  = FC_EARLY;
            state_d = ST_IDLE;
          end else if (!o_ovf_i) begin
            state_d = ST_HOLD;
            cnt_d   = DW'(1);
          end else if (cnt_q >= DW'(MAX_DLY)) begin
            fail_d  = 1'b1;
            code_d  = FC_TIMEOUT;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + DW'(1);
          end
        end
        ST_HOLD: begin
          if (iovf_rise_s && oovf_rise_s) begin
            pass_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (o_ovf_i) begin
            fail_d  = 1'b1;
            code_d  = FC_GLITCH;
            state_d = ST_IDLE;
          end else if (iovf_rise_s) begin
            fail_d  = 1'b1;
            code_d  = FC_ORDER;
            state_d = ST_IDLE;
          end else if ((HOLD_MAX != 0) && (cnt_q >= DW'(HOLD_MAX))) begin
            fail_d  = 1'b1;
            code_d  = FC_HOLD_TO;
            state_d = ST_IDLE;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + DW'(1);
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter, edge history and verdict pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      start_prev_q <= 1'b0;
      oovf_prev_q  <= 1'b0;
      iovf_prev_q  <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
      code_q       <= FC_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      start_prev_q <= start_i;
      oovf_prev_q  <= o_ovf_i;
      iovf_prev_q  <= i_ovf_i;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      code_q       <= code_d;
    end
  end

  assign pass_o = pass_q;
  assign fail_o = fail_q;
  assign code_o = code_q;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: rtl/ovf_seq_monitor.sv
// Multi-channel overflow-sequence monitor: one ovf_chan_fsm per channel plus
// sticky failure flags, saturating verdict totals and last-failure capture.
module ovf_seq_monitor
  import ovf_mon_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned MIN_DLY  = 2,
  parameter int unsigned MAX_DLY  = 20,
  parameter int unsigned HOLD_MAX = 0,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic [N_CH-1:0]   start,
  input  logic [N_CH-1:0]   o_ovf,
  input  logic [N_CH-1:0]   i_ovf,
  output logic [N_CH-1:0]   pass_o,
  output logic [N_CH-1:0]   fail_o,
  output logic [N_CH-1:0]   fail_sticky,
  output logic [N_CH-1:0]   busy,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic [2:0]        last_fail_code,
  output logic [CH_W-1:0]   last_fail_chan
);

  fail_code_e code_s [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ovf_chan_fsm #(
      .MIN_DLY (MIN_DLY),
      .MAX_DLY (MAX_DLY),
      .HOLD_MAX(HOLD_MAX)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en),
      .start_i(start[g]),
      .o_ovf_i(o_ovf[g]),
      .i_ovf_i(i_ovf[g]),
      .pass_o (pass_o[g]),
      .fail_o (fail_o[g]),
      .code_o (code_s[g]),
      .busy_o (busy[g])
    );
  end

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [5:0] b);
    logic [CNT_W+6:0] s;
    s = {7'd0, a} + {{(CNT_W + 1){1'b0}}, b};
    return (s > {7'd0, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  logic [N_CH-1:0]  sticky_q;
  logic [CNT_W-1:0] pass_cnt_q, fail_cnt_q;
  fail_code_e       lf_code_q, lf_code_d;
  logic [CH_W-1:0]  lf_chan_q, lf_chan_d;
  logic [5:0]       pass_pop_s, fail_pop_s;

  // Lowest failing channel wins, so scan from the top down.
  always_comb begin
    pass_pop_s = popcount32(32'(pass_o));
    fail_pop_s = popcount32(32'(fail_o));
    lf_code_d  = lf_code_q;
    lf_chan_d  = lf_chan_q;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      lf_code_d = fail_o[i] ? code_s[i] : lf_code_d;
      lf_chan_d = fail_o[i] ? CH_W'(i) : lf_chan_d;
    end
  end

  // Status aggregation over the visible verdict pulses; clr overrides.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q   <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      lf_code_q  <= FC_NONE;
      lf_chan_q  <= '0;
    end else if (clr) begin
      sticky_q   <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      lf_code_q  <= FC_NONE;
      lf_chan_q  <= '0;
    end else begin
      sticky_q   <= sticky_q | fail_o;
      pass_cnt_q <= sat_add(pass_cnt_q, pass_pop_s);
      fail_cnt_q <= sat_add(fail_cnt_q, fail_pop_s);
      lf_code_q  <= lf_code_d;
      lf_chan_q  <= lf_chan_d;
    end
  end

  assign fail_sticky    = sticky_q;
  assign pass_cnt       = pass_cnt_q;
  assign fail_cnt       = fail_cnt_q;
  assign last_fail_code = lf_code_q;
  assign last_fail_chan = lf_chan_q;

endmodule

// File: doc/ovf_seq_monitor.md
OVF_SEQ_MONITOR -- requirements
Module: ovf_seq_monitor

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent channels (1..32).
REQ-002 SHALL have parameter MIN_DLY, default 2, earliest legal o_ovf fall, in cycles after arm.
REQ-003 SHALL have parameter MAX_DLY, default 20, latest legal o_ovf fall, in cycles after arm (MIN_DLY<=MAX_DLY, MIN_DLY>=1).
REQ-004 SHALL have parameter HOLD_MAX, default 0, hold-phase timeout in cycles; 0 = unbounded.
REQ-005 SHALL have parameter CNT_W, default 16, width of the event counters.
REQ-006 SHALL have ports, clock and reset first: clk in 1 clock, rising edge | rst_n in 1 async active-low reset | en in 1 monitor enable | clr in 1 sync clear of status/counters.
REQ-007 SHALL have ports start, o_ovf and i_ovf, each in N_CH, per-channel observed signals.
REQ-008 SHALL have ports pass_o and fail_o, each out N_CH, one-cycle verdict pulses; fail_sticky out N_CH latched failures; busy out N_CH, channel armed.
REQ-009 SHALL have ports pass_cnt and fail_cnt, each out CNT_W, saturating totals.
REQ-010 SHALL have ports last_fail_code out 3, most recent fail code; last_fail_chan out max(1,$clog2(N_CH)), its channel.

Function
REQ-011 Each channel SHALL run an identical independent FSM: IDLE, WAIT_FALL, HOLD.
REQ-012 Rise detection SHALL compare each input with its registered previous sample, which resets to 0, so a signal high on the first cycle after reset counts as a rise.
REQ-013 IDLE: on a start rise with en=1, the FSM SHALL go to WAIT_FALL if o_ovf=1 (arm cycle t0), else report fail code 1 NOHI and stay in IDLE.
REQ-014 WAIT_FALL: the first cycle t0+k with o_ovf=0 SHALL report code 2 EARLY if k<MIN_DLY, otherwise move to HOLD.
REQ-015 WAIT_FALL: if o_ovf is still 1 at t0+MAX_DLY, the FSM SHALL report code 3 TIMEOUT on that cycle.
REQ-016 HOLD: a cycle with i_ovf rise and o_ovf rise together SHALL report pass; o_ovf=1 without an i_ovf rise SHALL report code 4 GLITCH; an i_ovf rise with o_ovf=0 SHALL report code 5 ORDER.
REQ-017 HOLD: with HOLD_MAX>0 and no verdict HOLD_MAX cycles after entry, the FSM SHALL report code 6 HOLD_TO.
REQ-018 Every verdict SHALL return the FSM to IDLE; start rises while not IDLE SHALL be ignored.
REQ-019 pass_o/fail_o SHALL pulse exactly one cycle, registered, in the cycle after the deciding sample (latency 1).
REQ-020 busy SHALL be 1 exactly while the FSM is in WAIT_FALL or HOLD.
REQ-021 en=0 SHALL force all FSMs to IDLE without a verdict; edge registers keep sampling.
REQ-022 fail_o SHALL set the matching fail_sticky bit, which holds until clr or reset.
REQ-023 Counters SHALL add the popcount of same-cycle pass_o/fail_o bits and saturate at all-ones.
REQ-024 On simultaneous failures, last_fail_code/last_fail_chan SHALL record the lowest failing channel index.
REQ-025 clr=1 SHALL zero fail_sticky, counters and last_fail_*, with priority over same-cycle updates; FSMs SHALL be unaffected.
REQ-026 The delay counter SHALL be $clog2(max(MAX_DLY,HOLD_MAX)+1) bits and SHALL never wrap within a phase.

Reset
REQ-027 rst_n low SHALL asynchronously force all FSMs to IDLE and zero all outputs, counters, edge registers and fail_sticky.
REQ-028 Reset mid-operation SHALL abandon the sequence with no verdict pulse.

Structure
REQ-029 Package ovf_mon_pkg SHALL hold the FSM state enum and the 3-bit fail-code enum (0 NONE, 1 NOHI .. 6 HOLD_TO).
REQ-030 Sub-module ovf_chan_fsm (one channel: edge registers, FSM, delay counter) SHALL be instantiated N_CH times by generate; aggregation (counters, last_fail) SHALL stay in the top.

Verification
REQ-031 ch0: start rise at cycle 10 with o_ovf=1, o_ovf=0 at 15, i_ovf and o_ovf rise at 17 -> pass_o[0] at 18, pass_cnt=1.
REQ-032 ch0: o_ovf=0 at t0+1 -> fail_o[0] at t0+2, last_fail_code=2, fail_sticky[0]=1.
REQ-033 ch0: o_ovf held 1 after arm -> fail_o[0] at t0+21 with code 3; with HOLD_MAX=5, a hold lasting 6 cycles -> code 6.
REQ-034 Hold phase, o_ovf returns to 1 with i_ovf=0 -> code 4; i_ovf rises with o_ovf=0 -> code 5.
REQ-035 ch1 and ch3 fail in the same cycle -> fail_cnt +2, last_fail_chan=1; clr next cycle -> all status 0.
REQ-036 rst_n low during HOLD -> busy=0 with no pulse; start held 1 through reset release -> arms on the first cycle after release.
